iterative_sqrt_invoker: RTL

Control-side sequencer placed directly upstream of `iterative_sqrt_wrapper`. It accepts operands from a host elastic stream and issues one invocation per operand: an `n` token plus a `start` token. It then collects both the `out0` and `end` tokens from the kernel and returns the operand paired with its result on a response stream. At most one invocation is outstanding at a time, and the block keeps a saturating invocation counter and a sticky protocol-error flag.

---
 rtl/iterative_sqrt_pkg.sv | 13 +
 rtl/iterative_sqrt_invoker_elastic_once.sv | 27 ++
 rtl/iterative_sqrt_invoker.sv | 115 +++++++++++
 3 files changed

// File: rtl/iterative_sqrt_pkg.sv
// Shared types and default widths for the iterative_sqrt invoker.
package iterative_sqrt_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/iterative_sqrt_invoker_elastic_once.sv
// One-shot handshake tracker: offers valid/ready until a single transfer,
// then holds a done flag until the next invocation clears it.
module elastic_once (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  input  logic peer,
  output logic drive_c,
  output logic fire_c,
  output logic flag
);

  assign drive_c = enable && !flag;
  assign fire_c  = drive_c && peer;

  always_ff @(posedge clk) begin
    if (rst) begin
      flag <= 1'b0;
    end else if (clear) begin
      flag <= 1'b0;
    end else if (fire_c) begin
      flag <= 1'b1;
    end
  end

endmodule

// File: rtl/iterative_sqrt_invoker.sv
// Sequencer issuing one n/start invocation per host operand to the sqrt
// kernel and returning (operand, result) pairs, one invocation at a time.
module iterative_sqrt_invoker
  import iterative_sqrt_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [CNT_WIDTH-1:0]  invocations,
  output logic                  protocol_err,
  output logic                  busy,
  input  logic [DATA_WIDTH-1:0] in_n,
  input  logic                  in_n_valid,
  output logic                  in_n_ready,
  output logic [DATA_WIDTH-1:0] res_n,
  output logic [DATA_WIDTH-1:0] res_sqrt,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] k_n,
  output logic                  k_n_valid,
  input  logic                  k_n_ready,
  output logic                  k_start_valid,
  input  logic                  k_start_ready,
  input  logic [DATA_WIDTH-1:0] k_out0,
  input  logic                  k_out0_valid,
  output logic                  k_out0_ready,
  input  logic                  k_end_valid,
  output logic                  k_end_ready
);

  state_e state, state_nxt;
  logic [DATA_WIDTH-1:0] op_q, sqrt_q;
  logic run, in_fire, res_fire, all_done;
  logic n_fire, start_fire, out_fire, end_fire;
  logic n_flag, start_flag, out_flag, end_flag;

  assign in_fire  = in_n_valid && in_n_ready;
  assign res_fire = res_valid && res_ready;

  // Flags set this cycle count, so a same-cycle final token moves to RESP.
  assign all_done = (n_flag || n_fire) && (start_flag || start_fire) &&
                    (out_flag || out_fire) && (end_flag || end_fire);

  elastic_once u_n (
    .clk(clk), .rst(rst), .clear(in_fire), .enable(run), .peer(k_n_ready),
    .drive_c(k_n_valid), .fire_c(n_fire), .flag(n_flag)
  );
  elastic_once u_start (
    .clk(clk), .rst(rst), .clear(in_fire), .enable(run), .peer(k_start_ready),
    .drive_c(k_start_valid), .fire_c(start_fire), .flag(start_flag)
  );
  elastic_once u_out (
    .clk(clk), .rst(rst), .clear(in_fire), .enable(run), .peer(k_out0_valid),
    .drive_c(k_out0_ready), .fire_c(out_fire), .flag(out_flag)
  );
  elastic_once u_end (
    .clk(clk), .rst(rst), .clear(in_fire), .enable(run), .peer(k_end_valid),
    .drive_c(k_end_ready), .fire_c(end_fire), .flag(end_flag)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_fire)  state_nxt = RUN;
      RUN:     if (all_done) state_nxt = RESP;
      RESP:    if (res_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_n_ready = 1'b0;
    res_valid  = 1'b0;
    run        = 1'b0;
    busy       = 1'b1;
    unique case (state)
      IDLE: begin
        in_n_ready = 1'b1;
        busy       = 1'b0;
      end
      RUN:     run       = 1'b1;
      RESP:    res_valid = 1'b1;
      default: busy      = 1'b0;
    endcase
  end

  assign k_n      = op_q;
  assign res_n    = op_q;
  assign res_sqrt = sqrt_q;

  // Operand/result capture, saturating counter and sticky kernel-protocol flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q         <= '0;
      sqrt_q       <= '0;
      invocations  <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (in_fire)  op_q   <= in_n;
      if (out_fire) sqrt_q <= k_out0;
      if (res_fire && (invocations != {CNT_WIDTH{1'b1}}))
        invocations <= invocations + CNT_WIDTH'(1);
      if ((state != RUN) && (k_out0_valid || k_end_valid))
        protocol_err <= 1'b1;
    end
  end

endmodule
